register_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single memory-mapped register bus (8-bit address, 32-bit write data, write enable, registered read data) between requester A and requester B, for example the host packet handler and an on-chip sequencer. It sits directly in front of the register file. It serialises accesses, issues one bus transaction at a time, and routes returned read data to the requester that issued the read. Read data returns after a fixed latency.

---
 rtl/register_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_register_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_bus_arbiter.sv
// rtl/register_bus_arbiter.sv - two-requester register bus arbiter; REG_ARB_ROUND_ROBIN_EN selects round-robin
module register_bus_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     ipClk,
  input  logic                     ipReset,
  input  logic                     ipA_Valid,
  input  logic [ADDRESS_WIDTH-1:0] ipA_Address,
  input  logic [DATA_WIDTH-1:0]    ipA_WrData,
  input  logic                     ipA_WrEnable,
  output logic                     opA_Ready,
  output logic [DATA_WIDTH-1:0]    opA_RdData,
  output logic                     opA_RdValid,
  input  logic                     ipB_Valid,
  input  logic [ADDRESS_WIDTH-1:0] ipB_Address,
  input  logic [DATA_WIDTH-1:0]    ipB_WrData,
  input  logic                     ipB_WrEnable,
  output logic                     opB_Ready,
  output logic [DATA_WIDTH-1:0]    opB_RdData,
  output logic                     opB_RdValid,
  output logic [ADDRESS_WIDTH-1:0] opAddress,
  output logic [DATA_WIDTH-1:0]    opWrData,
  output logic                     opWrEnable,
  input  logic [DATA_WIDTH-1:0]    ipRdData
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_e;

  state_e                   state_q, state_d;
  logic                     owner_b_q, owner_b_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic                     a_ready_q, a_ready_d;
  logic                     b_ready_q, b_ready_d;
  logic [DATA_WIDTH-1:0]    a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0]    b_rdata_q, b_rdata_d;
  logic                     a_rvalid_q, a_rvalid_d;
  logic                     b_rvalid_q, b_rvalid_d;
  logic                     pick_b;

`ifdef REG_ARB_ROUND_ROBIN_EN
  logic last_b_q, last_b_d;

  // Round-robin: on contention the requester not granted last wins
  always_comb begin
    pick_b = ipB_Valid && (!ipA_Valid || !last_b_q);
  end

  // Pointer tracks the most recent grant; reset value makes A win first
  always_comb begin
    last_b_d = last_b_q;
    if (state_q == IDLE && (ipA_Valid || ipB_Valid)) begin
      last_b_d = pick_b;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  // Fixed priority: A always wins, B only when A is idle
  always_comb begin
    pick_b = ipB_Valid && !ipA_Valid;
  end
`endif

  // Next-state and registered-output logic of the bus FSM
  always_comb begin
    state_d    = state_q;
    owner_b_d  = owner_b_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    a_ready_d  = 1'b0;
    b_ready_d  = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ipA_Valid || ipB_Valid) begin
          state_d   = GRANT;
          owner_b_d = pick_b;
          addr_d    = pick_b ? ipB_Address  : ipA_Address;
          wdata_d   = pick_b ? ipB_WrData   : ipA_WrData;
          we_d      = pick_b ? ipB_WrEnable : ipA_WrEnable;
          a_ready_d = !pick_b;
          b_ready_d = pick_b;
        end
      end
      GRANT: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (owner_b_q) begin
            b_rdata_d  = ipRdData;
            b_rvalid_d = 1'b1;
          end else begin
            a_rdata_d  = ipRdData;
            a_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight read
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q    <= IDLE;
      owner_b_q  <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      a_ready_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_b_q  <= owner_b_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      a_ready_q  <= a_ready_d;
      b_ready_q  <= b_ready_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign opA_Ready   = a_ready_q;
  assign opB_Ready   = b_ready_q;
  assign opA_RdData  = a_rdata_q;
  assign opB_RdData  = b_rdata_q;
  assign opA_RdValid = a_rvalid_q;
  assign opB_RdValid = b_rvalid_q;
  assign opAddress   = addr_q;
  assign opWrData    = wdata_q;
  assign opWrEnable  = we_q;

endmodule

// File: tb/tb_register_bus_arbiter.sv
// tb/tb_register_bus_arbiter.sv - directed bench for register_bus_arbiter (latency 1 and 3 instances)
module tb_register_bus_arbiter;

`ifdef REG_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // latency-1 instance
  logic        a_valid, a_we, a_ready, a_rvalid;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_we, b_ready, b_rvalid;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_we;

  // latency-3 instance
  logic        c_a_valid, c_a_we, c_a_ready, c_a_rvalid;
  logic [7:0]  c_a_addr;
  logic [31:0] c_a_wdata, c_a_rdata;
  logic        c_b_valid, c_b_we, c_b_ready, c_b_rvalid;
  logic [7:0]  c_b_addr;
  logic [31:0] c_b_wdata, c_b_rdata;
  logic [7:0]  c_bus_addr;
  logic [31:0] c_bus_wdata, c_bus_rdata;
  logic        c_bus_we;

  int vectors = 0;
  int errors  = 0;

  register_bus_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
    .ipClk(clk), .ipReset(rst_n),
    .ipA_Valid(a_valid), .ipA_Address(a_addr), .ipA_WrData(a_wdata), .ipA_WrEnable(a_we),
    .opA_Ready(a_ready), .opA_RdData(a_rdata), .opA_RdValid(a_rvalid),
    .ipB_Valid(b_valid), .ipB_Address(b_addr), .ipB_WrData(b_wdata), .ipB_WrEnable(b_we),
    .opB_Ready(b_ready), .opB_RdData(b_rdata), .opB_RdValid(b_rvalid),
    .opAddress(bus_addr), .opWrData(bus_wdata), .opWrEnable(bus_we), .ipRdData(bus_rdata)
  );

  register_bus_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
    .ipClk(clk), .ipReset(rst_n),
    .ipA_Valid(c_a_valid), .ipA_Address(c_a_addr), .ipA_WrData(c_a_wdata), .ipA_WrEnable(c_a_we),
    .opA_Ready(c_a_ready), .opA_RdData(c_a_rdata), .opA_RdValid(c_a_rvalid),
    .ipB_Valid(c_b_valid), .ipB_Address(c_b_addr), .ipB_WrData(c_b_wdata), .ipB_WrEnable(c_b_we),
    .opB_Ready(c_b_ready), .opB_RdData(c_b_rdata), .opB_RdValid(c_b_rvalid),
    .opAddress(c_bus_addr), .opWrData(c_bus_wdata), .opWrEnable(c_bus_we), .ipRdData(c_bus_rdata)
  );

  // register file read model: value depends on address, delayed by the read latency
  function automatic logic [31:0] model_rd(input logic [7:0] a);
    return 32'h12345678 ^ {24'h0, a};
  endfunction

  logic [31:0] p1;
  logic [31:0] c_p0, c_p1, c_p2;
  always @(posedge clk) begin
    p1   <= model_rd(bus_addr);
    c_p0 <= model_rd(c_bus_addr);
    c_p1 <= c_p0;
    c_p2 <= c_p1;
  end
  assign bus_rdata   = p1;
  assign c_bus_rdata = c_p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_a;
    rst_n = 1'b0;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h11; a_wdata = 32'h1;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 8'h22; b_wdata = 32'h2;
    c_a_valid = 1'b0; c_a_we = 1'b0; c_a_addr = 8'h0; c_a_wdata = 32'h0;
    c_b_valid = 1'b0; c_b_we = 1'b0; c_b_addr = 8'h0; c_b_wdata = 32'h0;

    // reset held with both requests pending
    tick(); tick();
    check("rst_a_ready", {31'h0, a_ready}, 32'h0);
    check("rst_b_ready", {31'h0, b_ready}, 32'h0);
    check("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    check("rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
    check("rst_we", {31'h0, bus_we}, 32'h0);
    check("rst_addr", {24'h0, bus_addr}, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check("rst3_we", {31'h0, c_bus_we}, 32'h0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_a_ready", {31'h0, a_ready}, 32'h0);

    // A write 0x02 <= 0xA5
    a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h02; a_wdata = 32'h000000A5;
    tick();
    check("aw_ready", {31'h0, a_ready}, 32'h1);
    check("aw_b_ready", {31'h0, b_ready}, 32'h0);
    check("aw_we", {31'h0, bus_we}, 32'h1);
    check("aw_addr", {24'h0, bus_addr}, 32'h02);
    check("aw_wdata", bus_wdata, 32'h000000A5);
    a_valid = 1'b0;
    tick();
    check("aw_we_drop", {31'h0, bus_we}, 32'h0);
    check("aw_ready_drop", {31'h0, a_ready}, 32'h0);
    check("aw_addr_hold", {24'h0, bus_addr}, 32'h02);

    // B read 0x00, latency 1
    b_valid = 1'b1; b_we = 1'b0; b_addr = 8'h00;
    tick();
    check("br_ready", {31'h0, b_ready}, 32'h1);
    check("br_we", {31'h0, bus_we}, 32'h0);
    check("br_addr", {24'h0, bus_addr}, 32'h00);
    b_valid = 1'b0;
    tick();
    check("br_wait_rvalid", {31'h0, b_rvalid}, 32'h0);
    tick();
    check("br_rvalid", {31'h0, b_rvalid}, 32'h1);
    check("br_rdata", b_rdata, 32'h12345678);
    check("br_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    tick();
    check("br_rvalid_drop", {31'h0, b_rvalid}, 32'h0);
    check("br_rdata_hold", b_rdata, 32'h12345678);

    // continuous writes from both requesters
    a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 32'h111;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 32'h222;
    for (int i = 0; i < 4; i++) begin
      exp_a = RR ? (i % 2 == 0) : 1'b1;
      tick();
      check("cw_a_ready", {31'h0, a_ready}, {31'h0, exp_a});
      check("cw_b_ready", {31'h0, b_ready}, {31'h0, !exp_a});
      check("cw_we", {31'h0, bus_we}, 32'h1);
      check("cw_addr", {24'h0, bus_addr}, exp_a ? 32'h10 : 32'h20);
      tick();
      check("cw_gap_we", {31'h0, bus_we}, 32'h0);
    end
    a_valid = 1'b0;
    tick();
    check("cw_b_after_a", {31'h0, b_ready}, 32'h1);
    check("cw_b_wdata", bus_wdata, 32'h222);
    b_valid = 1'b0;
    tick();

    // reset during a write grant drops the strobe asynchronously
    a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wdata = 32'hDEADBEEF;
    tick();
    check("rw_we_pre", {31'h0, bus_we}, 32'h1);
    a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rw_we_async", {31'h0, bus_we}, 32'h0);
    check("rw_ready_async", {31'h0, a_ready}, 32'h0);
    check("rw_addr_async", {24'h0, bus_addr}, 32'h0);
    rst_n = 1'b1;

    // reset during WAIT of an A read abandons it
    a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h09;
    tick();
    check("ra_ready", {31'h0, a_ready}, 32'h1);
    a_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("ra_no_rvalid0", {31'h0, a_rvalid}, 32'h0);
    tick();
    check("ra_no_rvalid1", {31'h0, a_rvalid}, 32'h0);
    check("ra_rdata_clr", a_rdata, 32'h0);

    // next A read is served normally
    a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h05;
    tick();
    check("na_ready", {31'h0, a_ready}, 32'h1);
    a_valid = 1'b0;
    tick();
    check("na_wait", {31'h0, a_rvalid}, 32'h0);
    tick();
    check("na_rvalid", {31'h0, a_rvalid}, 32'h1);
    check("na_rdata", a_rdata, 32'h1234567D);
    check("na_b_rvalid", {31'h0, b_rvalid}, 32'h0);

    // latency 3: A read with B write pending
    c_a_valid = 1'b1; c_a_we = 1'b0; c_a_addr = 8'h07;
    c_b_valid = 1'b1; c_b_we = 1'b1; c_b_addr = 8'h30; c_b_wdata = 32'hCAFE0001;
    tick();
    check("l3_a_ready", {31'h0, c_a_ready}, 32'h1);
    check("l3_b_wait", {31'h0, c_b_ready}, 32'h0);
    c_a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("l3_rvalid_early", {31'h0, c_a_rvalid}, 32'h0);
      check("l3_b_blocked", {31'h0, c_b_ready}, 32'h0);
    end
    tick();
    check("l3_rvalid", {31'h0, c_a_rvalid}, 32'h1);
    check("l3_rdata", c_a_rdata, 32'h1234567F);
    check("l3_b_rvalid", {31'h0, c_b_rvalid}, 32'h0);
    tick();
    check("l3_b_ready", {31'h0, c_b_ready}, 32'h1);
    check("l3_b_we", {31'h0, c_bus_we}, 32'h1);
    check("l3_b_addr", {24'h0, c_bus_addr}, 32'h30);
    check("l3_rvalid_drop", {31'h0, c_a_rvalid}, 32'h0);
    c_b_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
